sort_feeder: RTL and testbench

Upstream framing stage for the comparator-cell sort chain. It accepts a frame of key/value pairs over a valid/ready stream and drives the chain's shared enable, key and value inputs one pair per enabled cycle. After the last pair it injects sentinel flush entries so every held pair settles into its final cell, then raises the chain's done input. It reports frame completion once the chain's ready is observed.

---
 rtl/sort_pkg.sv | 18 +
 rtl/sort_feeder.sv | 172 +++++++++++++++++
 tb/tb_sort_feeder.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the sort chain feeder and its bench: widths, flush sentinel, state encoding.
package sort_pkg;

  localparam int KEY_WIDTH = 32;
  localparam int VAL_WIDTH = 16;

  // Reserved key used by flush entries; real keys are never allowed to equal it
  localparam logic [KEY_WIDTH-1:0] SENTINEL = {KEY_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/sort_feeder.sv
// Frames key/value pairs into the comparator sort chain, flushes it with sentinels and waits for its ready.
// Optional macro SORT_FEEDER_SENTINEL_EN remaps all-ones input keys and raises a sticky o_sat flag.
module sort_feeder
  import sort_pkg::*;
#(
  parameter int key_width   = KEY_WIDTH,
  parameter int val_width   = VAL_WIDTH,
  parameter int depth       = 8,
  parameter int count_width = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_start,
  input  logic [count_width-1:0] i_len,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [key_width-1:0]   s_key,
  input  logic [val_width-1:0]   s_val,
  output logic                   o_chain_rstn,
  output logic                   o_en,
  output logic [key_width-1:0]   o_key,
  output logic [val_width-1:0]   o_val,
  output logic                   o_done,
  input  logic                   i_chain_ready,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic                   o_err,
  output logic                   o_sat
);

  localparam int FlushW = $clog2(depth + 1);
  localparam logic [key_width-1:0] KeyOnes = {key_width{1'b1}};

  state_e                 state_q, state_d;
  logic [count_width-1:0] len_q, len_d;
  logic [count_width-1:0] beat_q, beat_d, beat_inc;
  logic [FlushW-1:0]      flush_q, flush_d;
  logic                   chain_rstn_q, chain_rstn_d;
  logic                   en_q, en_d;
  logic [key_width-1:0]   key_q, key_d;
  logic [val_width-1:0]   val_q, val_d;
  logic                   done_q, done_d;
  logic                   frame_done_q, frame_done_d;
  logic                   err_q, err_d;
  logic                   hs;
`ifdef SORT_FEEDER_SENTINEL_EN
  logic                   sat_q, sat_d;
`endif

  assign s_ready  = (state_q == ST_LOAD);
  assign hs       = s_valid && s_ready;
  assign beat_inc = beat_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    beat_d       = beat_q;
    flush_d      = flush_q;
    chain_rstn_d = 1'b1;
    en_d         = 1'b0;
    key_d        = key_q;
    val_d        = val_q;
    done_d       = done_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
`ifdef SORT_FEEDER_SENTINEL_EN
    sat_d        = sat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            len_d        = i_len;
            beat_d       = '0;
            flush_d      = '0;
            chain_rstn_d = 1'b0;
            state_d      = ST_CLEAR;
`ifdef SORT_FEEDER_SENTINEL_EN
            sat_d        = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_CLEAR: state_d = ST_LOAD;
      ST_LOAD: begin
        if (hs) begin
          en_d   = 1'b1;
          key_d  = s_key;
          val_d  = s_val;
          beat_d = beat_inc;
`ifdef SORT_FEEDER_SENTINEL_EN
          // A real key must never look like a flush entry to the chain
          if (s_key == KeyOnes) begin
            key_d = KeyOnes - 1'b1;
            sat_d = 1'b1;
          end
`endif
          if (beat_inc == len_q) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_q == FlushW'(depth)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          en_d    = 1'b1;
          key_d   = KeyOnes;
          val_d   = '0;
          flush_d = flush_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (i_chain_ready) begin
          frame_done_d = 1'b1;
          done_d       = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      beat_q       <= '0;
      flush_q      <= '0;
      chain_rstn_q <= 1'b1;
      en_q         <= 1'b0;
      key_q        <= KeyOnes;
      val_q        <= '0;
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      flush_q      <= flush_d;
      chain_rstn_q <= chain_rstn_d;
      en_q         <= en_d;
      key_q        <= key_d;
      val_q        <= val_d;
      done_q       <= done_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

`ifdef SORT_FEEDER_SENTINEL_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end
  assign o_sat = sat_q;
`else
  assign o_sat = 1'b0;
`endif

  assign o_chain_rstn = chain_rstn_q;
  assign o_en         = en_q;
  assign o_key        = key_q;
  assign o_val        = val_q;
  assign o_done       = done_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_frame_done = frame_done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_sort_feeder.sv
// Bench for sort_feeder: per-frame traces compared against expected beat/flush schedule derived from handshakes.
module tb_sort_feeder;
  import sort_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_len = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_key = '0;
  logic [15:0] s_val = '0;
  logic        o_chain_rstn, o_en, o_done, o_busy, o_frame_done, o_err, o_sat;
  logic [31:0] o_key;
  logic [15:0] o_val;
  logic        i_chain_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [31:0] tx_keys[$];
  logic [15:0] tx_vals[$];

  always #5 clk = ~clk;

  sort_feeder #(.key_width(32), .val_width(16), .depth(DEPTH), .count_width(16)) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_len(i_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_key(s_key), .s_val(s_val),
    .o_chain_rstn(o_chain_rstn), .o_en(o_en), .o_key(o_key), .o_val(o_val),
    .o_done(o_done), .i_chain_ready(i_chain_ready), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_err(o_err), .o_sat(o_sat)
  );

  function automatic logic [31:0] map_key(input logic [31:0] k);
`ifdef SORT_FEEDER_SENTINEL_EN
    return (k == SENTINEL) ? 32'hFFFF_FFFE : k;
`else
    return k;
`endif
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_chain_rstn, o_en, o_key, o_val, o_done, o_busy, o_frame_done, o_err, o_sat, s_ready} !==
        {1'b1, 1'b0, 32'hFFFF_FFFF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: rstn=%b en=%b key=%h val=%h done=%b busy=%b fd=%b err=%b sat=%b rdy=%b",
               o_chain_rstn, o_en, o_key, o_val, o_done, o_busy, o_frame_done, o_err, o_sat, s_ready);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random valid
  task automatic run_frame(input string name, input int len, input int mode, input bit inject);
    logic        tr_en  [0:255];
    logic [31:0] tr_key [0:255];
    logic [15:0] tr_val [0:255];
    int          hs_cyc[$];
    int          t, sent, rst_low, done_cyc, last, w;
    bit          injected, exp_sat, e_en, exp_rdy;
    logic [31:0] e_key;
    logic [15:0] e_val;

    exp_sat = 1'b0;
    for (int i = 0; i < len; i++) if (map_key(tx_keys[i]) != tx_keys[i]) exp_sat = 1'b1;

    i_start = 1'b1;
    i_len   = 16'(len);
    @(posedge clk); #1;
    i_start = 1'b0;
    t = 0; sent = 0; rst_low = 0; done_cyc = -1; injected = 1'b0;
    while (t < 200 && done_cyc < 0) begin
      case (mode)
        0:       s_valid = (sent < len);
        1:       s_valid = (sent < len) && (t % 2 == 1);
        default: s_valid = (sent < len) && ($urandom_range(0, 1) == 1);
      endcase
      s_key = (sent < len) ? tx_keys[sent] : $urandom;
      s_val = (sent < len) ? tx_vals[sent] : 16'($urandom);
      if (inject && sent == 1 && !injected) begin
        i_start = 1'b1; i_len = 16'd7; injected = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
      tr_en[t] = o_en; tr_key[t] = o_key; tr_val[t] = o_val;
      if (!o_chain_rstn) rst_low++;
      if (t == 0) begin
        checks++;
        if (o_busy !== 1'b1 || o_sat !== 1'b0) begin
          errors++;
          $display("FAIL %s clear_cycle: busy=%b sat=%b want busy=1 sat=0", name, o_busy, o_sat);
        end
      end
      exp_rdy = (t >= 1) && (sent < len);
      checks++;
      if (s_ready !== exp_rdy) begin
        errors++;
        $display("FAIL %s s_ready cyc%0d: got %b want %b", name, t, s_ready, exp_rdy);
      end
      if (s_valid && exp_rdy) begin
        hs_cyc.push_back(t);
        sent++;
      end
      if (o_done) done_cyc = t;
      @(posedge clk); #1;
      t++;
    end
    s_valid = 1'b0;
    i_start = 1'b0;

    checks++;
    if (done_cyc < 0 || hs_cyc.size() != len) begin
      errors++;
      $display("FAIL %s timeout: beats=%0d want %0d done_cyc=%0d", name, hs_cyc.size(), len, done_cyc);
      return;
    end
    checks++;
    if (rst_low != 1) begin
      errors++;
      $display("FAIL %s chain_rstn_low: got %0d cycles want 1", name, rst_low);
    end
    last = hs_cyc[len-1];
    for (int c = 0; c <= done_cyc; c++) begin
      e_en = 1'b0; e_key = '0; e_val = '0;
      for (int i = 0; i < len; i++)
        if (hs_cyc[i] + 1 == c) begin
          e_en = 1'b1; e_key = map_key(tx_keys[i]); e_val = tx_vals[i];
        end
      if (c >= last + 2 && c <= last + 1 + DEPTH) begin
        e_en = 1'b1; e_key = 32'hFFFF_FFFF; e_val = 16'h0;
      end
      checks++;
      if (tr_en[c] !== e_en || (e_en && (tr_key[c] !== e_key || tr_val[c] !== e_val))) begin
        errors++;
        $display("FAIL %s beat cyc%0d: got en=%b key=%h val=%h want en=%b key=%h val=%h",
                 name, c, tr_en[c], tr_key[c], tr_val[c], e_en, e_key, e_val);
      end
    end
    checks++;
    if (done_cyc != last + 2 + DEPTH) begin
      errors++;
      $display("FAIL %s done_time: got cyc%0d want cyc%0d", name, done_cyc, last + 2 + DEPTH);
    end
    checks++;
    if (o_sat !== exp_sat) begin
      errors++;
      $display("FAIL %s sat: got %b want %b", name, o_sat, exp_sat);
    end

    w = $urandom_range(0, 3);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      checks++;
      if (o_done !== 1'b1 || o_frame_done !== 1'b0 || o_en !== 1'b0) begin
        errors++;
        $display("FAIL %s done_hold: done=%b fd=%b en=%b want 1 0 0", name, o_done, o_frame_done, o_en);
      end
      @(posedge clk); #1;
    end
    i_chain_ready = 1'b1;
    @(posedge clk); #1;
    i_chain_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (o_frame_done !== 1'b1 || o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s frame_done: fd=%b done=%b busy=%b want 1 0 0", name, o_frame_done, o_done, o_busy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (o_frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s frame_done_pulse: got %b want 0", name, o_frame_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    tx_keys = {32'd5, 32'd2, 32'd9};
    tx_vals = {16'h0a01, 16'h0a02, 16'h0a03};
    run_frame("basic", 3, 0, 1'b0);
  endtask

  task automatic test_stall();
    tx_keys = {32'h100, 32'h0, 32'h7fff_ffff, 32'h42};
    tx_vals = {16'h1, 16'h2, 16'h3, 16'h4};
    run_frame("stall", 4, 1, 1'b0);
  endtask

  task automatic test_zero_len();
    i_start = 1'b1; i_len = 16'd0;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    checks++;
    if (o_err !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len err: err=%b busy=%b want 1 0", o_err, o_busy);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (o_err !== 1'b0 || o_busy !== 1'b0 || o_chain_rstn !== 1'b1) begin
      errors++;
      $display("FAIL zero_len after: err=%b busy=%b crst=%b want 0 0 1", o_err, o_busy, o_chain_rstn);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_in_load();
    tx_keys = {32'd30, 32'd10, 32'd20};
    tx_vals = {16'h3, 16'h1, 16'h2};
    run_frame("start_in_load", 3, 0, 1'b1);
  endtask

  task automatic test_reset_flush();
    bit found;
    found = 1'b0;
    i_start = 1'b1; i_len = 16'd2;
    @(posedge clk); #1;
    i_start = 1'b0;
    s_valid = 1'b1; s_key = 32'd7; s_val = 16'h77;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (o_en && o_key == 32'hFFFF_FFFF && o_val == 16'h0) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    s_valid = 1'b0;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_flush reach_flush: got no flush beat want one within 40 cycles");
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({o_chain_rstn, o_en, o_key, o_val, o_done, o_busy, o_frame_done, o_err, o_sat, s_ready} !==
        {1'b1, 1'b0, 32'hFFFF_FFFF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_flush values: rstn=%b en=%b key=%h val=%h done=%b busy=%b fd=%b err=%b sat=%b rdy=%b",
               o_chain_rstn, o_en, o_key, o_val, o_done, o_busy, o_frame_done, o_err, o_sat, s_ready);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    tx_keys = {32'd11, 32'd4};
    tx_vals = {16'hb, 16'h4};
    run_frame("after_reset", 2, 0, 1'b0);
  endtask

  task automatic test_sentinel();
    tx_keys = {32'd3, 32'hFFFF_FFFF, 32'd1};
    tx_vals = {16'h33, 16'hff, 16'h11};
    run_frame("sentinel", 3, 0, 1'b0);
    // next frame without the reserved key must start with o_sat cleared
    tx_keys = {32'd8};
    tx_vals = {16'h8};
    run_frame("sentinel_clear", 1, 0, 1'b0);
  endtask

  task automatic test_random();
    int len;
    for (int f = 0; f < 4; f++) begin
      len = (f == 3) ? 12 : $urandom_range(1, 10);
      tx_keys.delete();
      tx_vals.delete();
      for (int i = 0; i < len; i++) begin
        tx_keys.push_back(($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom));
        tx_vals.push_back(16'($urandom));
      end
      run_frame("random", len, 2, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_start_in_load();
    test_reset_flush();
    test_sentinel();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
